// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg: shared TAP definitions.
//   tap_state_e  - 16 TAP states with the standard 1149.1 4-bit encodings
//   IR_IDCODE    - instruction value selecting the IDCODE register
//   IR_USER_BASE - instruction value of user data register 0
//   tap_next()   - next-state function of the TAP FSM on TMS
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TAP_EX2_DR   = 4'h0,
    TAP_EX1_DR   = 4'h1,
    TAP_SH_DR    = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EX2_IR   = 4'h8,
    TAP_EX1_IR   = 4'h9,
    TAP_SH_IR    = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_e;

  localparam int IR_IDCODE    = 1;
  localparam int IR_USER_BASE = 2;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TAP_TLR;
    case (s)
      TAP_TLR:      n = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      n = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   n = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   n = tms ? TAP_EX1_DR   : TAP_SH_DR;
      TAP_SH_DR:    n = tms ? TAP_EX1_DR   : TAP_SH_DR;
      TAP_EX1_DR:   n = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: n = tms ? TAP_EX2_DR   : TAP_PAUSE_DR;
      TAP_EX2_DR:   n = tms ? TAP_UPD_DR   : TAP_SH_DR;
      TAP_UPD_DR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   n = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   n = tms ? TAP_EX1_IR   : TAP_SH_IR;
      TAP_SH_IR:    n = tms ? TAP_EX1_IR   : TAP_SH_IR;
      TAP_EX1_IR:   n = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: n = tms ? TAP_EX2_IR   : TAP_PAUSE_IR;
      TAP_EX2_IR:   n = tms ? TAP_UPD_IR   : TAP_SH_IR;
      TAP_UPD_IR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
      default:      n = TAP_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: TAP state register plus state decodes.
//   tck_i, rst_i, tms_i - JTAG clock, async active-high reset, mode select
//   state_o             - current TAP state
//   *_o strobes         - one-hot decodes of the state register, valid for
//                         the whole cycle spent in that state
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tck_i,
  input  logic       rst_i,
  input  logic       tms_i,
  output tap_state_e state_o,
  output logic       tlr_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       capture_ir_o,
  output logic       shift_ir_o,
  output logic       update_ir_o
);

  tap_state_e state;

  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) state <= TAP_TLR;
    else       state <= tap_next(state, tms_i);
  end

  assign state_o      = state;
  assign tlr_o        = (state == TAP_TLR);
  assign capture_dr_o = (state == TAP_CAP_DR);
  assign shift_dr_o   = (state == TAP_SH_DR);
  assign update_dr_o  = (state == TAP_UPD_DR);
  assign capture_ir_o = (state == TAP_CAP_IR);
  assign shift_ir_o   = (state == TAP_SH_IR);
  assign update_ir_o  = (state == TAP_UPD_IR);

endmodule

// File: rtl/jtag_tap_gen.sv
// jtag_tap_gen: IEEE 1149.1 TAP controller with IDCODE, BYPASS and
// NUM_USER_DR externally held user data registers.
//   tck_i/rst_i           - JTAG clock, async active-high reset (TRST)
//   tms_i/td_i            - mode select, serial data in
//   td_o/td_oe_o          - serial data out (combinational) and its enable
//   scan_in_o             - td_i forwarded to the user registers
//   shift/capture/update_dr_o - DR strobes, only when a user DR is selected
//   user_sel_o/user_out_i - one-hot user select, user serial outputs
//   tlr_o/tap_state_o     - Test-Logic-Reset flag, raw state for debug
module jtag_tap_gen
  import jtag_tap_pkg::*;
#(
  parameter int          IR_WIDTH     = 5,
  parameter logic [31:0] IDCODE_VALUE = 32'h10000db3,
  parameter int          NUM_USER_DR  = 5
) (
  input  logic                   tck_i,
  input  logic                   rst_i,
  input  logic                   tms_i,
  input  logic                   td_i,
  output logic                   td_o,
  output logic                   td_oe_o,
  output logic                   scan_in_o,
  output logic                   shift_dr_o,
  output logic                   capture_dr_o,
  output logic                   update_dr_o,
  output logic [NUM_USER_DR-1:0] user_sel_o,
  input  logic [NUM_USER_DR-1:0] user_out_i,
  output logic                   tlr_o,
  output logic [3:0]             tap_state_o
);

  localparam logic [IR_WIDTH-1:0] IR_ID   = IR_WIDTH'(IR_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_ONES = '1;

  tap_state_e state;
  logic tlr, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;

  jtag_tap_fsm u_fsm (
    .tck_i        (tck_i),
    .rst_i        (rst_i),
    .tms_i        (tms_i),
    .state_o      (state),
    .tlr_o        (tlr),
    .capture_dr_o (cap_dr),
    .shift_dr_o   (sh_dr),
    .update_dr_o  (upd_dr),
    .capture_ir_o (cap_ir),
    .shift_ir_o   (sh_ir),
    .update_ir_o  (upd_ir)
  );

  logic [IR_WIDTH-1:0]    ir_shift, ir_q;
  logic [31:0]            idcode_sr;
  logic                   bypass_q;
  logic [NUM_USER_DR-1:0] user_sel;
  logic                   sel_idcode, sel_user, sel_bypass;

  // Instruction decode from the latched IR; anything unrecognised is BYPASS.
  always_comb begin
    user_sel   = '0;
    sel_idcode = (ir_q == IR_ID);
    if (!sel_idcode && ir_q != IR_ONES) begin
      for (int k = 0; k < NUM_USER_DR; k++)
        if (ir_q == IR_WIDTH'(IR_USER_BASE + k)) user_sel[k] = 1'b1;
    end
    sel_user   = |user_sel;
    sel_bypass = !sel_idcode && !sel_user;
  end

  // IR: capture loads ...01 (same bit pattern as IDCODE), TLR forces IDCODE.
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      ir_shift <= '0;
      ir_q     <= IR_ID;
    end else begin
      if (cap_ir)     ir_shift <= IR_ID;
      else if (sh_ir) ir_shift <= {td_i, ir_shift[IR_WIDTH-1:1]};
      if (tlr)         ir_q <= IR_ID;
      else if (upd_ir) ir_q <= ir_shift;
    end
  end

  // Built-in DRs only move while they are the selected register.
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      idcode_sr <= IDCODE_VALUE;
      bypass_q  <= 1'b0;
    end else begin
      if (sel_idcode && cap_dr)     idcode_sr <= IDCODE_VALUE;
      else if (sel_idcode && sh_dr) idcode_sr <= {td_i, idcode_sr[31:1]};
      if (sel_bypass && cap_dr)     bypass_q <= 1'b0;
      else if (sel_bypass && sh_dr) bypass_q <= td_i;
    end
  end

  always_comb begin
    td_o = 1'b0;
    if (sh_ir)
      td_o = ir_shift[0];
    else if (sh_dr) begin
      if (sel_idcode)    td_o = idcode_sr[0];
      else if (sel_user) td_o = |(user_sel & user_out_i);
      else               td_o = bypass_q;
    end
  end

  assign td_oe_o      = sh_ir | sh_dr;
  assign scan_in_o    = td_i;
  assign shift_dr_o   = sh_dr  & sel_user;
  assign capture_dr_o = cap_dr & sel_user;
  assign update_dr_o  = upd_dr & sel_user;
  assign user_sel_o   = user_sel;
  assign tlr_o        = tlr;
  assign tap_state_o  = state;

endmodule

// File: tb/tb_jtag_tap_gen.sv
// Testbench for jtag_tap_gen: directed TMS/TDI sequences; expected TDO bits
// are queued by the stimulus and popped by a negedge monitor whenever td_oe_o
// is high.
module tb_jtag_tap_gen;

  localparam logic [31:0] ID = 32'h10000db3;

  logic       tck = 1'b0, rst_i = 1'b1, tms_i = 1'b1, td_i = 1'b0;
  logic       td_o, td_oe_o, scan_in_o, shift_dr_o, capture_dr_o, update_dr_o, tlr_o;
  logic [4:0] user_sel_o, user_out_i = '0;
  logic [3:0] tap_state_o;

  jtag_tap_gen dut (
    .tck_i(tck), .rst_i(rst_i), .tms_i(tms_i), .td_i(td_i),
    .td_o(td_o), .td_oe_o(td_oe_o), .scan_in_o(scan_in_o),
    .shift_dr_o(shift_dr_o), .capture_dr_o(capture_dr_o), .update_dr_o(update_dr_o),
    .user_sel_o(user_sel_o), .user_out_i(user_out_i),
    .tlr_o(tlr_o), .tap_state_o(tap_state_o)
  );

  always #5 tck = ~tck;

  int    checks = 0, failures = 0;
  logic  exp_q[$];
  string cur = "reset";
  logic  strobe_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: TDO is only meaningful while td_oe_o is high.
  initial forever begin
    @(negedge tck);
    if (capture_dr_o | shift_dr_o | update_dr_o) strobe_seen = 1'b1;
    if (td_oe_o) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL %s unexpected_tdo actual=%b required=<none>", cur, td_o);
      end else begin
        chk({cur, "_tdo"}, 32'(td_o), 32'(exp_q.pop_front()));
      end
    end else begin
      chk("tdo_idle", 32'(td_o), 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic step(input logic tms, input logic tdi);
    tms_i = tms; td_i = tdi;
    @(posedge tck); #1;
  endtask

  task automatic go_shift_dr; step(1, 0); step(0, 0); step(0, 0); endtask
  task automatic go_shift_ir; step(1, 0); step(1, 0); step(0, 0); step(0, 0); endtask
  task automatic exit_update; step(1, 0); step(0, 0); endtask

  // Shift cycles start..start+n-1 of a scan; optionally exit on the last one.
  task automatic shift_bits(input int start, input int n, input logic [63:0] din,
                            input logic [63:0] dexp, input logic ex);
    for (int i = start; i < start + n; i++) begin
      exp_q.push_back(dexp[i]);
      step(ex && (i == start + n - 1), din[i]);
    end
  endtask

  task automatic load_ir(input logic [4:0] v);
    go_shift_ir;
    shift_bits(0, 5, 64'(v), 64'h1, 1);
    exit_update;
  endtask

  task automatic read_idcode(input string name);
    cur = name;
    go_shift_dr;
    shift_bits(0, 32, 64'h0, 64'(ID), 1);
    exit_update;
  endtask

  logic [63:0] pat, pexp;

  initial begin
    // Reset state
    #12;
    chk("rst_tlr", 32'(tlr_o), 1);
    chk("rst_state", 32'(tap_state_o), 4'hF);
    chk("rst_sel", 32'(user_sel_o), 0);
    chk("rst_strobes", {29'd0, capture_dr_o, shift_dr_o, update_dr_o}, 0);
    chk("rst_oe", 32'(td_oe_o), 0);
    @(posedge tck); #1; rst_i = 1'b0;
    td_i = 1'b1; #1; chk("scan_in", 32'(scan_in_o), 1); td_i = 1'b0;
    step(0, 0);

    // IDCODE read after reset, no strobes
    strobe_seen = 1'b0;
    read_idcode("idcode");
    chk("idcode_nostrobe", 32'(strobe_seen), 0);

    // IR capture/load of user 1, DR strobes
    cur = "ir_load";
    go_shift_ir;
    shift_bits(0, 5, 64'h03, 64'h01, 1);
    step(1, 0);
    chk("sel_in_upd_ir", 32'(user_sel_o), 0);
    step(0, 0);
    chk("sel_user1", 32'(user_sel_o), 5'b00010);
    step(1, 0);
    chk("cap_in_sel", 32'(capture_dr_o), 0);
    step(0, 0);
    chk("cap_dr", 32'(capture_dr_o), 1);
    chk("sh_in_cap", 32'(shift_dr_o), 0);
    step(0, 0);
    chk("sh_dr", 32'(shift_dr_o), 1);
    chk("cap_in_sh", 32'(capture_dr_o), 0);
    cur = "user1";
    user_out_i = 5'b00010; exp_q.push_back(1'b1); step(0, 0);
    user_out_i = 5'b11101; exp_q.push_back(1'b0); step(1, 0);
    chk("sh_in_ex1", 32'(shift_dr_o), 0);
    step(1, 0);
    chk("upd_dr", 32'(update_dr_o), 1);
    step(0, 0);
    chk("upd_in_rti", 32'(update_dr_o), 0);

    // TMS reset from Shift-DR
    cur = "tms_rst";
    go_shift_dr;
    user_out_i = 5'b00010; exp_q.push_back(1'b1);
    step(1, 0);
    repeat (4) step(1, 0);
    chk("tms_tlr", 32'(tlr_o), 1);
    chk("tms_state", 32'(tap_state_o), 4'hF);
    step(1, 0);
    chk("tms_sel", 32'(user_sel_o), 0);
    step(0, 0);
    read_idcode("tms_idcode");

    // BYPASS: all-ones and an unused code
    strobe_seen = 1'b0;
    cur = "bypass_ones";
    load_ir(5'b11111);
    chk("bypass_sel", 32'(user_sel_o), 0);
    go_shift_dr;
    shift_bits(0, 5, 64'b01101, 64'b11010, 1);
    exit_update;
    cur = "bypass_unused";
    load_ir(5'b11000);
    chk("unused_sel", 32'(user_sel_o), 0);
    go_shift_dr;
    shift_bits(0, 5, 64'b01101, 64'b11010, 1);
    exit_update;
    chk("bypass_nostrobe", 32'(strobe_seen), 0);

    // Decode boundaries
    cur = "decode";
    load_ir(5'd7); chk("sel_ir7", 32'(user_sel_o), 0);
    load_ir(5'd6); chk("sel_ir6", 32'(user_sel_o), 5'b10000);
    load_ir(5'd2); chk("sel_ir2", 32'(user_sel_o), 5'b00001);

    // Pause mid-IDCODE shift; tdi bits emerge after 32 shifts
    cur = "pause";
    load_ir(5'd1);
    chk("sel_idcode", 32'(user_sel_o), 0);
    pat  = 64'h0000_000B_5A3C_96E1;
    pexp = {28'd0, pat[3:0], ID};
    go_shift_dr;
    shift_bits(0, 10, pat, pexp, 1);
    step(0, 0); step(0, 0); step(0, 0);
    chk("pause_state", 32'(tap_state_o), 4'h3);
    step(1, 0); step(0, 0);
    shift_bits(10, 26, pat, pexp, 1);
    exit_update;

    // Async reset during Shift-IR
    cur = "rst_mid";
    load_ir(5'd4);
    chk("sel_user2", 32'(user_sel_o), 5'b00100);
    go_shift_ir;
    exp_q.push_back(1'b1); step(0, 1);
    exp_q.push_back(1'b0); step(0, 1);
    strobe_seen = 1'b0;
    rst_i = 1'b1; #1;
    chk("mid_tlr", 32'(tlr_o), 1);
    chk("mid_state", 32'(tap_state_o), 4'hF);
    chk("mid_sel", 32'(user_sel_o), 0);
    chk("mid_oe", 32'(td_oe_o), 0);
    @(posedge tck); #1; rst_i = 1'b0;
    chk("mid_noupd", 32'(strobe_seen), 0);
    step(0, 0);
    read_idcode("mid_idcode");

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_tap_gen.md
# jtag_tap_gen

Parametrised IEEE 1149.1 TAP controller for the SoC debug/test path: 16-state TAP FSM, IR of configurable width, built-in IDCODE and BYPASS registers, and a configurable number of one-hot-selected user data registers that live outside the block. It sits between the chip JTAG pads and the debug module and test-register chains. It provides real shift/capture/update sequencing and TDO muxing.

## Interface
- `IR_WIDTH`, default 5: instruction register width (≥2).
- `IDCODE_VALUE`, default 32'h10000db3: IDCODE contents; bit 0 must be 1.
- `NUM_USER_DR`, default 5: number of external user data registers (1..2^IR_WIDTH−3).
- `tck_i` in 1: JTAG clock. All state changes on its rising edge.
- `rst_i` in 1: asynchronous, active-high reset (TRST equivalent).
- `tms_i` in 1: test mode select.
- `td_i` in 1: test data in.
- `td_o` out 1: test data out.
- `td_oe_o` out 1: TDO output enable.
- `scan_in_o` out 1: `td_i` forwarded to user registers.
- `shift_dr_o`, `capture_dr_o`, `update_dr_o` out 1 each: DR phase strobes, qualified by user selection.
- `user_sel_o` out NUM_USER_DR: one-hot user register select.
- `user_out_i` in NUM_USER_DR: serial outputs (LSB side) of the user registers.
- `tlr_o` out 1: high while in Test-Logic-Reset.
- `tap_state_o` out 4: current FSM state, for debug.

## Operation
- FSM: standard 16 states (TLR, RTI, Select-DR, Capture-DR, Shift-DR, Exit1-DR, Pause-DR, Exit2-DR, Update-DR, and the IR mirrors). Transitions follow 1149.1 on `tms_i`. Five consecutive TMS=1 cycles reach TLR from any state.
- Instruction decode, using the latched IR:
  - IR = all-ones: BYPASS.
  - IR = 1: IDCODE.
  - IR = k+2 for k < NUM_USER_DR: user register k.
  - Any other value: BYPASS.
- IR shift register:
  - Capture-IR loads {0…0,01}.
  - Shift-IR shifts right, with `td_i` entering the MSB.
  - Update-IR copies it to the latched IR.
  - TLR sets the latched IR to IDCODE (1).
- IDCODE register (32 bit): Capture-DR loads `IDCODE_VALUE`; Shift-DR shifts right with `td_i` in.
- BYPASS register (1 bit): Capture-DR loads 0; Shift-DR loads `td_i`.
- User selection:
  - `user_sel_o[k]` is high whenever the latched IR selects k; otherwise 0.
  - `shift_dr_o`/`capture_dr_o`/`update_dr_o` are high in the matching state only when a user register is selected. IDCODE and BYPASS never assert them.
- TDO mux:
  - Shift-IR: IR shift register bit 0.
  - Shift-DR: bit 0 of the selected DR (IDCODE, bypass, or `user_out_i[k]`).
  - Otherwise 0.
- `td_oe_o` is high exactly in Shift-IR and Shift-DR.
- `scan_in_o` = `td_i` combinationally.

## Timing
- Reset values (`rst_i` high, asynchronous): state = TLR, latched IR = 1, IR shift = 0, IDCODE shift = `IDCODE_VALUE`, bypass = 0.
  - Resulting outputs: `tlr_o`=1, `tap_state_o`=TLR code, `user_sel_o`=0, all strobes 0, `td_o`=0, `td_oe_o`=0.
- Reset asserted mid-shift aborts the scan. No Update occurs and the latched IR returns to IDCODE.
- Strobes, `tlr_o`, `td_oe_o` and `tap_state_o` are decoded from the state register. They are valid for the whole cycle the FSM is in that state.
- The latched IR changes on the rising edge that leaves Update-IR. `user_sel_o` follows in the same cycle.
- `td_o` is combinational from state and shift-register bit 0. The first bit is visible in the first Shift cycle, before any shift edge. Falling-edge retiming for the pad is done outside this block.
- Capture occurs on the rising edge that leaves Capture-xR.
- Shift occurs on each rising edge while in Shift-xR, including the edge that exits to Exit1. N Shift-state cycles shift N bits.
- Pause states hold all shift registers.

## Structure
- `jtag_tap_pkg`: `tap_state_e` (4-bit enum, 1149.1 standard encodings), IR constant helpers (`IR_IDCODE`=1, `IR_USER_BASE`=2).
- Sub-module `jtag_tap_fsm`: state register plus next-state logic, and state-decode outputs.
- Top `jtag_tap_gen`: IR, IDCODE, bypass, decode, TDO mux.

## Test plan
- Reset, then read IDCODE:
  - Stimulus: assert `rst_i`, release, go to Shift-DR, shift 32 bits.
  - Required response: TDO sequence equals 32'h10000db3, LSB first. No strobes assert.
- TMS reset:
  - Stimulus: from Shift-DR, apply 5× TMS=1.
  - Required response: `tlr_o`=1 and IR reads back as IDCODE.
- IR capture and load:
  - Stimulus: shift in 5'b00011 via Shift-IR.
  - Required response: first two TDO bits are 1,0. After Update-IR, `user_sel_o`=5'b00010. Capture/Shift/Update-DR then pulse `capture_dr_o`, `shift_dr_o` and `update_dr_o` in the correct states, and TDO = `user_out_i[1]`.
- BYPASS delay:
  - Stimulus: load IR=5'b11111, shift pattern 1,0,1,1 through DR.
  - Required response: TDO shows 0 then the pattern delayed by 1 cycle. Repeat with unused IR=5'b11000 for the same result.
- Pause, then reset mid-scan:
  - Stimulus: enter Pause-DR mid-IDCODE shift and hold 3 cycles.
  - Required response: the register holds during Pause and shifting resumes correctly.
  - Stimulus: assert `rst_i` during Shift-IR.
  - Required response: immediate TLR, no `update_dr_o`, latched IR = 1.
